// File: rtl/bin_to_bcd_seq_pkg.sv
// bcd_pkg: shared defaults, FSM states and overflow code for the sequential binary-to-BCD converter.
package bcd_pkg;
    localparam int BIN_WIDTH_DEF = 20;
    localparam int NUM_DIGITS_DEF = 6;
    localparam longint MAX_VALUE = 999999;
    localparam logic [3:0] DIGIT_OVF = 4'hF;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    function automatic longint max_value(input int digits);
        longint v = 1;
        for (int i = 0; i < digits; i++) v = v * 10;
        return v - 1;
    endfunction
endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// bin_to_bcd_seq_if: request/result signals of the binary-to-BCD converter.
interface bin_to_bcd_seq_if import bcd_pkg::*; #(
    parameter int BIN_WIDTH = BIN_WIDTH_DEF,
    parameter int NUM_DIGITS = NUM_DIGITS_DEF
);
    logic start;
    logic [BIN_WIDTH-1:0] bin_in;
    logic busy;
    logic done;
    logic ovf;
    logic [4*NUM_DIGITS-1:0] bcd_out;
    modport master(output start, bin_in, input busy, done, ovf, bcd_out);
    modport slave(input start, bin_in, output busy, done, ovf, bcd_out);
endinterface

// File: rtl/bin_to_bcd_seq_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 to a BCD digit of 5 or more.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: one-bit-per-clock double-dabble converter, MSB first, with
// a held result register and an all-F display code for out-of-range inputs.
module bin_to_bcd_seq import bcd_pkg::*; #(
    parameter int BIN_WIDTH = BIN_WIDTH_DEF,
    parameter int NUM_DIGITS = NUM_DIGITS_DEF
) (
    input logic clk,
    input logic reset,
    bin_to_bcd_seq_if.slave bus
);
    localparam int SW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(BIN_WIDTH + 1);
    localparam logic [63:0] MAX_VAL = 64'(max_value(NUM_DIGITS));

    state_t state, state_nxt;
    logic [BIN_WIDTH-1:0] shreg;
    logic [SW-1:0] scratch, adj, bcd;
    logic [CW-1:0] cnt;
    logic ovf_cap, ovf_q, last;

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
        bcd_add3 u_add3 (.din(scratch[4*d +: 4]), .dout(adj[4*d +: 4]));
    end

    assign last = (cnt == CW'(BIN_WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.start ? SHIFT : IDLE;
            SHIFT:   state_nxt = last ? DONE : SHIFT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
            scratch <= '0;
            cnt <= '0;
            bcd <= '0;
            ovf_q <= 1'b0;
            ovf_cap <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            shreg <= bus.bin_in;
            scratch <= '0;
            cnt <= '0;
            ovf_cap <= 64'(bus.bin_in) > MAX_VAL;
        end else if (state == SHIFT) begin
            {scratch, shreg} <= {adj, shreg} << 1;
            cnt <= cnt + CW'(1);
            // The final shift result is taken straight from the corrected digits
            // so bcd_out is valid on the same edge that enters DONE.
            if (last) begin
                bcd <= ovf_cap ? {NUM_DIGITS{DIGIT_OVF}} : {adj[SW-2:0], shreg[BIN_WIDTH-1]};
                ovf_q <= ovf_cap;
            end
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.ovf = ovf_q;
    assign bus.bcd_out = bcd;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed vector table plus hand-written held-start, bin_in-change and reset-abort sequences.
module tb_bin_to_bcd_seq;
    logic clk = 0;
    logic reset;
    int checks = 0;
    int errors = 0;
    logic [23:0] prev_bcd;

    always #5 clk = ~clk;

    bin_to_bcd_seq_if bus ();
    bin_to_bcd_seq dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [19:0] v;
        logic [23:0] b;
        logic o;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, got, exp);
        end
    endtask

    // Called at #1 after an edge with the DUT in IDLE.
    task automatic conv(input logic [19:0] v, input logic [23:0] eb, input logic eo,
                        input bit chg, input string nm);
        int lat;
        bus.start = 1;
        bus.bin_in = v;
        @(posedge clk); #1;
        bus.start = 0;
        if (chg) bus.bin_in = 20'd5;
        lat = 1;
        while (!bus.done && lat < 40) begin
            if (lat == 10) chk({nm, "_hold"}, 64'(bus.bcd_out), 64'(prev_bcd));
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_lat"}, 64'(lat), 64'd21);
        chk({nm, "_bcd"}, 64'(bus.bcd_out), 64'(eb));
        chk({nm, "_ovf"}, 64'(bus.ovf), 64'(eo));
        prev_bcd = eb;
        @(posedge clk); #1;
        chk({nm, "_done_off"}, 64'(bus.done), 64'd0);
        chk({nm, "_idle"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int ndone;
        tbl[0]  = '{20'd0,       24'h000000, 1'b0};
        tbl[1]  = '{20'd123456,  24'h123456, 1'b0};
        tbl[2]  = '{20'd999999,  24'h999999, 1'b0};
        tbl[3]  = '{20'd1000000, 24'hFFFFFF, 1'b1};
        tbl[4]  = '{20'd42,      24'h000042, 1'b0};
        tbl[5]  = '{20'd1,       24'h000001, 1'b0};
        tbl[6]  = '{20'd9,       24'h000009, 1'b0};
        tbl[7]  = '{20'd10,      24'h000010, 1'b0};
        tbl[8]  = '{20'd99,      24'h000099, 1'b0};
        tbl[9]  = '{20'd500000,  24'h500000, 1'b0};
        tbl[10] = '{20'd1048575, 24'hFFFFFF, 1'b1};
        tbl[11] = '{20'd100,     24'h000100, 1'b0};

        reset = 1;
        bus.start = 1;
        bus.bin_in = 20'd77;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_bcd", 64'(bus.bcd_out), 64'd0);
        chk("rst_ovf", 64'(bus.ovf), 64'd0);
        reset = 0;
        bus.start = 0;
        prev_bcd = 24'h0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) conv(tbl[i].v, tbl[i].b, tbl[i].o, 1'b0, $sformatf("vec%0d", i));

        conv(20'd88, 24'h000088, 1'b0, 1'b1, "bin_change");

        // start held high: done on edges 21,43,65; IDLE on edges 22,44,66.
        bus.start = 1;
        bus.bin_in = 20'd7;
        ndone = 0;
        for (int e = 1; e <= 66; e++) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
            chk($sformatf("held_done_e%0d", e), 64'(bus.done), 64'(e % 22 == 21));
            chk($sformatf("held_busy_e%0d", e), 64'(bus.busy), 64'(e % 22 != 0));
        end
        chk("held_ndone", 64'(ndone), 64'd3);
        chk("held_bcd", 64'(bus.bcd_out), 64'h7);
        bus.start = 0;
        @(posedge clk); #1;

        bus.start = 1;
        bus.bin_in = 20'd555;
        @(posedge clk); #1;
        bus.start = 0;
        repeat (9) @(posedge clk);
        #1;
        chk("abort_midshift_busy", 64'(bus.busy), 64'd1);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("abort_bcd", 64'(bus.bcd_out), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_ovf", 64'(bus.ovf), 64'd0);
        ndone = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);
        chk("abort_bcd_held", 64'(bus.bcd_out), 64'd0);
        prev_bcd = 24'h0;
        conv(20'd555, 24'h000555, 1'b0, 1'b0, "after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 The block SHALL have parameter BIN_WIDTH, default 20, giving the binary input width.
REQ-002 The block SHALL have parameter NUM_DIGITS, default 6, giving the number of BCD output digits (one per HEX display).
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-005 Port start SHALL be an input, 1 bit: conversion request, sampled only in IDLE.
REQ-006 Port bin_in SHALL be an input, BIN_WIDTH bits: unsigned binary value, captured on the accepted start edge.
REQ-007 Port busy SHALL be an output, 1 bit: high whenever the state is not IDLE.
REQ-008 Port done SHALL be an output, 1 bit: one-cycle pulse marking a new valid bcd_out.
REQ-009 Port ovf SHALL be an output, 1 bit: the last captured value exceeded 10^NUM_DIGITS-1.
REQ-010 Port bcd_out SHALL be an output, 4*NUM_DIGITS bits: packed BCD digits, digit 0 (units) in [3:0], digit 5 in [23:20].

Function
REQ-011 The conversion SHALL use sequential shift-and-add-3 (double dabble), processing one input bit per clock, MSB first.
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-013 IDLE with start=1 at an edge SHALL capture bin_in into a shift register, clear the BCD scratch register, clear the bit counter, and go to SHIFT.
REQ-014 On each SHIFT edge, the FSM SHALL first add 3 to every scratch digit >= 5, then shift {scratch, shift register} left by one, and increment the counter.
REQ-015 The FSM SHALL go from SHIFT to DONE on the edge performing shift number BIN_WIDTH, so SHIFT lasts exactly BIN_WIDTH cycles.
REQ-016 On the edge entering DONE, bcd_out SHALL load the scratch value, or all digits 4'hF if the captured value exceeded 10^NUM_DIGITS-1.
REQ-017 done SHALL be high only while in DONE, i.e. for exactly one cycle, asserting BIN_WIDTH+1 edges after the accepted start edge (21 for defaults).
REQ-018 DONE SHALL always return to IDLE on the next edge; start during DONE or SHIFT SHALL be ignored and SHALL NOT be queued.
REQ-019 ovf SHALL update on the same edge as bcd_out and SHALL hold until the next completed conversion.
REQ-020 bcd_out SHALL hold its last value through IDLE and SHIFT, never showing partial results.
REQ-021 bin_in changes after the capture edge SHALL NOT affect the conversion in progress.
REQ-022 Scratch digits SHALL never exceed 9 after any shift for in-range inputs.

Reset
REQ-023 reset=1 at an edge SHALL force state IDLE, bcd_out=0, ovf=0, done=0, busy=0, counter=0, with priority over start.
REQ-024 Reset during SHIFT SHALL abort the conversion with no done pulse and bcd_out=0.

Structure
REQ-025 A shared package bcd_pkg SHALL hold the BIN_WIDTH and NUM_DIGITS defaults, MAX_VALUE (999999), the state enumeration, and the digit-overflow code 4'hF.
REQ-026 A combinational sub-module bcd_add3 (4-bit in, 4-bit out: +3 if >= 5) SHALL be instantiated once per digit.
REQ-027 Each bcd_out nibble SHALL be directly connectable to one seven-segment decoder input.

Verification
REQ-028 Reset, then start with bin_in=0 -> done on the 21st edge after start; bcd_out=24'h000000; ovf=0.
REQ-029 bin_in=123456 -> bcd_out=24'h123456; bin_in=999999 -> bcd_out=24'h999999; ovf=0 for both.
REQ-030 bin_in=1000000 -> ovf=1, bcd_out=24'hFFFFFF; a following bin_in=42 -> ovf=0, bcd_out=24'h000042.
REQ-031 start held high continuously with bin_in=7 -> exactly one conversion per 22 cycles; done pulses one cycle wide; busy low only in the IDLE cycle.
REQ-032 bin_in changed to 5 on the cycle after a start with bin_in=88 -> result 24'h000088.
REQ-033 reset pulsed at SHIFT cycle 10 of bin_in=555 -> no done, bcd_out=0; a new start then yields 24'h000555.
